// File: rtl/upc_pkg.sv
// Shared UPC types, catalog codes and entry FSM states.
// UPC_PARITY_EN adds a fourth, even-parity bit to each entry.
package upc_pkg;

    typedef logic [2:0] upc_t;

    localparam upc_t UPC_SIAMESE = 3'b000;
    localparam upc_t UPC_PERSIAN = 3'b001;
    localparam upc_t UPC_COON    = 3'b011;
    localparam upc_t UPC_FOLD    = 3'b100;
    localparam upc_t UPC_BENGAL  = 3'b101;
    localparam upc_t UPC_RAGDOLL = 3'b110;

`ifdef UPC_PARITY_EN
    localparam int unsigned N_BITS = 4;
`else
    localparam int unsigned N_BITS = 3;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CHECK
    } entry_state_t;

    function automatic logic is_cat(input upc_t code);
        logic hit;
        case (code)
            UPC_SIAMESE, UPC_PERSIAN, UPC_COON,
            UPC_FOLD, UPC_BENGAL, UPC_RAGDOLL: hit = 1'b1;
            default:                           hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/strobe_edge.sv
// Rising-edge detector for the entry key; the register resets high so a key
// held through reset is not seen as a press.
module strobe_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic strobe_i,
    output logic edge_o
);

    logic strobe_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            strobe_q <= 1'b1;
        end else begin
            strobe_q <= strobe_i;
        end
    end

    assign edge_o = strobe_i & ~strobe_q;

endmodule

// File: rtl/upc_entry.sv
// Serial UPC entry: MSB-first bit collection, inter-bit timeout and catalog
// check. Define UPC_PARITY_EN to collect and verify a trailing parity bit.
module upc_entry
    import upc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       bit_in,
    input  logic       strobe,
    output logic [2:0] upc,
    output logic       upc_valid,
    output logic       upc_error,
    output logic       busy
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned CW = 3;

    entry_state_t        state_q, state_d;
    logic [N_BITS-1:0]   shift_q, shift_d;
    logic [CW-1:0]       count_q, count_d;
    logic [TW-1:0]       timer_q, timer_d;
    upc_t                upc_q, upc_d;
    logic                valid_q, valid_d;
    logic                error_q, error_d;
    logic                busy_q, busy_d;
    logic                strobe_rise;
    upc_t                code;
    logic                code_ok;

    strobe_edge u_strobe_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .strobe_i (strobe),
        .edge_o   (strobe_rise)
    );

`ifdef UPC_PARITY_EN
    assign code    = shift_q[3:1];
    assign code_ok = is_cat(code) && (shift_q[0] == ^code);
`else
    assign code    = shift_q;
    assign code_ok = is_cat(code);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            count_q <= '0;
            timer_q <= '0;
            upc_q   <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            timer_q <= timer_d;
            upc_q   <= upc_d;
            valid_q <= valid_d;
            error_q <= error_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        timer_d = timer_q;
        upc_d   = upc_q;
        valid_d = 1'b0;
        error_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                count_d = '0;
                if (strobe_rise) begin
                    shift_d = {{(N_BITS-1){1'b0}}, bit_in};
                    count_d = CW'(1);
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // An edge on the threshold cycle takes priority over the timeout.
                if (strobe_rise) begin
                    shift_d = {shift_q[N_BITS-2:0], bit_in};
                    count_d = count_q + CW'(1);
                    timer_d = '0;
                    if (count_q == CW'(N_BITS - 1)) begin
                        state_d = ST_CHECK;
                    end
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    error_d = 1'b1;
                    count_d = '0;
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_CHECK: begin
                count_d = '0;
                if (code_ok) begin
                    upc_d   = code;
                    valid_d = 1'b1;
                end else begin
                    error_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
                timer_d = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign upc       = upc_q;
    assign upc_valid = valid_q;
    assign upc_error = error_q;
    assign busy      = busy_q;

endmodule
